sequence_checker: RTL and testbench

//  Receive-side checker for the 5-symbol repeating stream 1,2,3,6,4,1,2,...

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_symbol_lut.sv | 17 +
 rtl/sequence_checker.sv | 135 +++++++++++++
 tb/tb_sequence_checker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the repeating 1,2,3,6,4 link sequence.
// The symbol generator and this checker both use the same table.
package seq_pkg;

    localparam int SEQ_LEN = 5;
    localparam logic [3:0] SEQ_SYM [0:SEQ_LEN-1] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd4};

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } chk_state_t;

    // Advance a table index, wrapping after the last symbol.
    function automatic logic [2:0] idx_inc(input logic [2:0] idx);
        return (idx == 3'(SEQ_LEN - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/seq_symbol_lut.sv
// Maps a sequence index to its symbol; indices past the table return 0.
module seq_symbol_lut
    import seq_pkg::*;
(
    input  logic [2:0] idx,
    output logic [3:0] symbol
);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        symbol = 4'd0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (idx == 3'(i)) symbol = SEQ_SYM[i];
        end
    end

endmodule

// File: rtl/sequence_checker.sv
// Receive-side checker for the 1,2,3,6,4 stream: hunt, confirm lock,
// then track the stream and flag/count symbol errors. All outputs registered.
module sequence_checker
    import seq_pkg::*;
#(
    parameter int LOCK_LEN    = 5,
    parameter int LOSS_THRESH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             period_done,
    output logic [3:0]       expected,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0] LOCK_L = 4'(LOCK_LEN);
    localparam logic [3:0] LOSS_L = 4'(LOSS_THRESH);

    chk_state_t       state, state_next;
    logic [2:0]       idx, idx_next;
    logic [3:0]       good, good_next;
    logic [3:0]       miss, miss_next;
    logic             err_evt, period_evt;
    logic             hit;
    logic             locked_next;
    logic [3:0]       exp_next;
    logic [CNT_W-1:0] cnt_next;

    // expected always holds SEQ[idx], so it doubles as the compare value.
    assign hit = (in_data == expected);

    seq_symbol_lut u_lut (
        .idx    (idx_next),
        .symbol (exp_next)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        good_next  = good;
        miss_next  = miss;
        err_evt    = 1'b0;
        period_evt = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_data == 4'd1) begin
                        state_next = SYNC;
                        idx_next   = 3'd1;
                        good_next  = 4'd1;
                    end
                end
                SYNC: begin
                    if (hit) begin
                        good_next = good + 4'd1;
                        idx_next  = idx_inc(idx);
                        if (good_next == LOCK_L) begin
                            state_next = LOCKED;
                            miss_next  = 4'd0;
                        end
                    end else if (in_data == 4'd1) begin
                        idx_next  = 3'd1;
                        good_next = 4'd1;
                    end else begin
                        state_next = HUNT;
                        idx_next   = 3'd0;
                        good_next  = 4'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the index advances on a miss too, keeping alignment.
                    idx_next = idx_inc(idx);
                    if (hit) begin
                        miss_next  = 4'd0;
                        period_evt = (idx == 3'(SEQ_LEN - 1));
                    end else begin
                        err_evt   = 1'b1;
                        miss_next = miss + 4'd1;
                        if (miss_next >= LOSS_L) begin
                            state_next = HUNT;
                            idx_next   = 3'd0;
                            good_next  = 4'd0;
                            miss_next  = 4'd0;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_comb begin
        locked_next = (state_next == LOCKED);
        cnt_next    = err_count;
        if (clr_cnt)
            cnt_next = '0;
        else if (err_evt && (err_count != {CNT_W{1'b1}}))
            cnt_next = err_count + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= 3'd0;
            good        <= 4'd0;
            miss        <= 4'd0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            period_done <= 1'b0;
            expected    <= 4'd1;
            err_count   <= '0;
        end else begin
            idx         <= idx_next;
            good        <= good_next;
            miss        <= miss_next;
            locked      <= locked_next;
            err_pulse   <= err_evt;
            period_done <= period_evt;
            expected    <= exp_next;
            err_count   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_sequence_checker.sv
// Self-checking bench for sequence_checker: directed scenarios plus random
// traffic, compared against a behavioural model of the stream rules.
module tb_sequence_checker;

    localparam int LOCK_LEN = 5;
    localparam int LOSS     = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = 4'd0;
    logic        clr_cnt = 1'b0;

    logic        locked, err_pulse, period_done;
    logic [3:0]  expected;
    logic [15:0] err_count;
    logic        locked_s, err_pulse_s, period_done_s;
    logic [3:0]  expected_s;
    logic [2:0]  err_count_s;

    int checks = 0;
    int errors = 0;

    int tbl [5] = '{1, 2, 3, 6, 4};

    // Behavioural model state
    bit m_lock;
    int m_pos;
    int m_run;
    int m_bad;
    bit m_err;
    bit m_per;
    int m_cnt;
    int m_cnt_s;

    always #5 clk = ~clk;

    sequence_checker #(.LOCK_LEN(LOCK_LEN), .LOSS_THRESH(LOSS), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .period_done(period_done),
        .expected(expected), .err_count(err_count)
    );

    sequence_checker #(.LOCK_LEN(LOCK_LEN), .LOSS_THRESH(LOSS), .CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
        .locked(locked_s), .err_pulse(err_pulse_s), .period_done(period_done_s),
        .expected(expected_s), .err_count(err_count_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_pos = 0; m_run = 0; m_bad = 0;
        m_err = 0; m_per = 0; m_cnt = 0; m_cnt_s = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit c);
        m_err = 0;
        m_per = 0;
        if (v) begin
            if (m_lock) begin
                if (d == tbl[m_pos]) begin
                    m_bad = 0;
                    m_per = (m_pos == 4);
                end else begin
                    m_err = 1;
                    m_bad++;
                end
                m_pos = (m_pos + 1) % 5;
                if (m_bad >= LOSS) begin
                    m_lock = 0; m_pos = 0; m_bad = 0; m_run = 0;
                end
            end else if (m_run > 0 && d == tbl[m_pos]) begin
                m_run++;
                m_pos = (m_pos + 1) % 5;
                if (m_run >= LOCK_LEN) begin
                    m_lock = 1;
                    m_bad  = 0;
                end
            end else if (d == 1) begin
                m_run = 1;
                m_pos = 1;
            end else begin
                m_run = 0;
                m_pos = 0;
            end
        end
        if (c) begin
            m_cnt   = 0;
            m_cnt_s = 0;
        end else if (m_err) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 7)   m_cnt_s++;
        end
    endtask

    task automatic check_model();
        chk("locked",      32'(locked),      32'(m_lock));
        chk("err_pulse",   32'(err_pulse),   32'(m_err));
        chk("period_done", 32'(period_done), 32'(m_per));
        chk("expected",    32'(expected),    32'(tbl[m_pos]));
        chk("err_count",   32'(err_count),   32'(m_cnt));
        chk("locked_s",    32'(locked_s),    32'(m_lock));
        chk("err_count_s", 32'(err_count_s), 32'(m_cnt_s));
    endtask

    task automatic step(input bit v, input logic [3:0] d, input bit c);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        clr_cnt  = c;
        @(posedge clk);
        model_step(v, int'(d), c);
        #1 check_model();
    endtask

    task automatic send(input int d);
        step(1'b1, 4'(d), 1'b0);
    endtask

    task automatic send_period();
        for (int i = 0; i < 5; i++) send(tbl[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int g;
        bit v;
        logic [3:0] d;

        // 1: clean stream, lock on the 5th symbol
        do_reset();
        for (int i = 0; i < 4; i++) send(tbl[i]);
        chk("t1_not_locked_yet", 32'(locked), 32'd0);
        send(tbl[4]);
        chk("t1_locked", 32'(locked), 32'd1);
        for (int k = 0; k < 10; k++) send(tbl[k % 5]);
        chk("t1_no_errors", 32'(err_count), 32'd0);

        // 2: same stream with random gaps
        do_reset();
        for (int k = 0; k < 15; k++) begin
            while ($urandom_range(0, 2) == 0) step(1'b0, 4'($urandom), 1'b0);
            send(tbl[k % 5]);
            if (k == 3) chk("t2_not_locked_yet", 32'(locked), 32'd0);
            if (k == 4) chk("t2_locked", 32'(locked), 32'd1);
        end

        // 3: single bad symbol while locked
        do_reset();
        send_period();
        send(1); send(2); send(7);
        chk("t3_err_pulse", 32'(err_pulse), 32'd1);
        send(6); send(4);
        chk("t3_period_done", 32'(period_done), 32'd1);
        chk("t3_err_count", 32'(err_count), 32'd1);
        chk("t3_still_locked", 32'(locked), 32'd1);

        // 4: two consecutive misses drop lock; relock from a fresh 1
        do_reset();
        send_period();
        send(9);
        chk("t4_locked_after_one", 32'(locked), 32'd1);
        send(9);
        chk("t4_lost", 32'(locked), 32'd0);
        chk("t4_err_count", 32'(err_count), 32'd2);
        send(2); send(3);
        chk("t4_hunt_expected", 32'(expected), 32'd1);
        send_period();
        chk("t4_relocked", 32'(locked), 32'd1);

        // 5: SYNC restart on a 1
        do_reset();
        send(1); send(2); send(1);
        send(2); send(3); send(6);
        chk("t5_not_locked", 32'(locked), 32'd0);
        send(4);
        chk("t5_locked", 32'(locked), 32'd1);

        // 6: saturation, clear-vs-error, reset mid-lock
        do_reset();
        send_period();
        for (int i = 0; i < 18; i++) send((i % 2 == 0) ? 9 : tbl[i % 5]);
        chk("t6_count_wide", 32'(err_count), 32'd9);
        chk("t6_count_sat", 32'(err_count_s), 32'd7);
        step(1'b1, 4'd9, 1'b1);
        chk("t6_clr_pulse", 32'(err_pulse), 32'd1);
        chk("t6_clr_count", 32'(err_count), 32'd0);
        send(tbl[m_pos]);
        chk("t6_locked_before_reset", 32'(locked), 32'd1);
        do_reset();
        chk("t6_reset_locked", 32'(locked), 32'd0);
        chk("t6_reset_expected", 32'(expected), 32'd1);

        // Random traffic against the model
        do_reset();
        g = 0;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 19) < 17) ? 4'(tbl[g % 5]) : 4'($urandom);
            if (v) g++;
            step(v, d, ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
